// File: rtl/button_pkg.sv
// Shared types and helpers for the button press classifier.
// Optional states are present only when BUTTON_DOUBLE_PRESS_EN is defined.
package button_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_RELEASE   = 3'd0,
        ST_IDLE           = 3'd1,
        ST_PRESSED        = 3'd2,
        ST_HELD           = 3'd3
`ifdef BUTTON_DOUBLE_PRESS_EN
        ,
        ST_WAIT_SECOND    = 3'd4,
        ST_SECOND_PRESSED = 3'd5
`endif
    } btn_state_t;

    // Which single-cycle event the FSM decided on this cycle.
    localparam logic [2:0] PULSE_NONE   = 3'd0;
    localparam logic [2:0] PULSE_SHORT  = 3'd1;
    localparam logic [2:0] PULSE_LONG   = 3'd2;
    localparam logic [2:0] PULSE_REPEAT = 3'd3;
    localparam logic [2:0] PULSE_DOUBLE = 3'd4;

    function automatic int ms_to_ticks(input int clk_per);
        return 1000000 / clk_per;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick is high for one cycle every TICK_CYC cycles,
// counted from the last synchronous clear.
module ms_tick_gen
#(
    parameter int TICK_CYC = 100000
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced button level into short/long/repeat/double press pulses.
// Double-press detection is compiled in with BUTTON_DOUBLE_PRESS_EN.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int CLK_PER   = 10,
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int DOUBLE_MS = 250
)
(
    input  logic clk,
    input  logic CPU_RESETN,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_press,
    output logic double_press,
    output logic held
);

    localparam int TICK_CYC = ms_to_ticks(CLK_PER);
    localparam int MS_W     = $clog2(max3(LONG_MS, REPEAT_MS, DOUBLE_MS) + 1);
    localparam logic [MS_W-1:0] LONG_TH   = MS_W'(LONG_MS);
    localparam logic [MS_W-1:0] REPEAT_TH = MS_W'(REPEAT_MS);
`ifdef BUTTON_DOUBLE_PRESS_EN
    localparam logic [MS_W-1:0] DOUBLE_TH = MS_W'(DOUBLE_MS);
`endif

    btn_state_t      state_reg, state_next;
    logic [MS_W-1:0] ms_reg, ms_inc;
    logic [2:0]      pulse_next;
    logic            restart;
    logic            clear;
    logic            tick;
    logic            short_reg, long_reg, repeat_reg, held_reg;

    ms_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
        .clk   (clk),
        .rst_n (CPU_RESETN),
        .clear (clear),
        .tick  (tick)
    );

    // ms_inc is the count as it would stand after this edge, so thresholds
    // fire on the edge the count reaches them.
    always_comb begin
        ms_inc     = (tick && ms_reg != '1) ? ms_reg + MS_W'(1) : ms_reg;
        state_next = state_reg;
        pulse_next = PULSE_NONE;
        restart    = 1'b0;
        case (state_reg)
            ST_WAIT_RELEASE: begin
                if (!btn_level) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (btn_level) state_next = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!btn_level) begin
`ifdef BUTTON_DOUBLE_PRESS_EN
                    state_next = ST_WAIT_SECOND;
`else
                    state_next = ST_IDLE;
                    pulse_next = PULSE_SHORT;
`endif
                end else if (ms_inc >= LONG_TH) begin
                    state_next = ST_HELD;
                    pulse_next = PULSE_LONG;
                end
            end
            ST_HELD: begin
                if (!btn_level) begin
                    state_next = ST_IDLE;
                end else if (ms_inc >= REPEAT_TH) begin
                    pulse_next = PULSE_REPEAT;
                    restart    = 1'b1;
                end
            end
`ifdef BUTTON_DOUBLE_PRESS_EN
            ST_WAIT_SECOND: begin
                if (btn_level) begin
                    state_next = ST_SECOND_PRESSED;
                end else if (ms_inc >= DOUBLE_TH) begin
                    state_next = ST_IDLE;
                    pulse_next = PULSE_SHORT;
                end
            end
            ST_SECOND_PRESSED: begin
                if (!btn_level) begin
                    state_next = ST_IDLE;
                    pulse_next = PULSE_DOUBLE;
                end
            end
`endif
            default: state_next = ST_WAIT_RELEASE;
        endcase
    end

    // Every state change, and every repeat, restarts the ms timebase.
    assign clear = (state_next != state_reg) || restart;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg  <= ST_WAIT_RELEASE;
            ms_reg     <= '0;
            short_reg  <= 1'b0;
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
            held_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ms_reg     <= clear ? '0 : ms_inc;
            short_reg  <= (pulse_next == PULSE_SHORT);
            long_reg   <= (pulse_next == PULSE_LONG);
            repeat_reg <= (pulse_next == PULSE_REPEAT);
            held_reg   <= (state_next == ST_HELD);
        end
    end

`ifdef BUTTON_DOUBLE_PRESS_EN
    logic double_reg;

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            double_reg <= 1'b0;
        end else begin
            double_reg <= (pulse_next == PULSE_DOUBLE);
        end
    end

    assign double_press = double_reg;
`else
    assign double_press = 1'b0;
`endif

    assign short_press  = short_reg;
    assign long_press   = long_reg;
    assign repeat_press = repeat_reg;
    assign held         = held_reg;

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies a debounced push-button level into short-press, long-press, auto-repeat and (optionally) double-press events, each a single-cycle pulse. Sits directly downstream of the button debouncer and upstream of the counter: it replaces the raw press pulse with classified events, so the counter can increment, reset or step on hold.

## Interface
- `CLK_PER`, 10, clock period in ns; must divide 1_000_000.
- `LONG_MS`, 500, hold time in ms that makes a press long; must be at least 1.
- `REPEAT_MS`, 100, auto-repeat period in ms while held after a long press; must be at least 1.
- `DOUBLE_MS`, 250, maximum release-to-second-press gap in ms for a double press; must be at least 1.
- `clk`  in  1  system clock.
- `CPU_RESETN`  in  1  reset; asynchronous, active-low.
- `btn_level`  in  1  debounced, clk-synchronous button level; high means pressed.
- `short_press`  out  1  one-cycle pulse.
- `long_press`  out  1  one-cycle pulse.
- `repeat_press`  out  1  one-cycle pulse.
- `double_press`  out  1  one-cycle pulse; constant 0 when the feature is compiled out.
- `held`  out  1  level; high while in HELD.

## Operation
- ms tick: `TICK_CYC = 1_000_000/CLK_PER` cycles per tick.
- Tick prescaler and ms counter clear on every FSM state change.
- ms counter saturates at its maximum and never wraps.
- ms counter width is `$clog2(max(LONG_MS, REPEAT_MS, DOUBLE_MS)+1)`.
- WAIT_RELEASE (reset state): `btn_level` low -> IDLE. This prevents a button held through reset from producing an event.
- IDLE: `btn_level` high -> PRESSED.
- PRESSED:
  - `btn_level` low -> WAIT_SECOND if the feature is enabled; otherwise pulse `short_press` and go to IDLE.
  - ms count reaches `LONG_MS` -> pulse `long_press` and go to HELD.
  - Release and threshold in the same cycle: release wins, and no `long_press` pulse is produced.
- HELD:
  - Every `REPEAT_MS` ms, pulse `repeat_press`. The repeat counter restarts after each pulse without leaving the state.
  - `btn_level` low -> IDLE with no pulse.
  - Release and repeat threshold in the same cycle: release wins.
- WAIT_SECOND:
  - `btn_level` high -> SECOND_PRESSED.
  - ms count reaches `DOUBLE_MS` -> pulse `short_press` and go to IDLE.
  - Press and timeout in the same cycle: press wins.
- SECOND_PRESSED: `btn_level` low -> pulse `double_press` and go to IDLE. Hold duration is ignored, and neither `long_press` nor `repeat_press` is produced.
- At most one pulse output is high in any cycle.

## Timing
- All outputs are registered.
- A pulse is high for exactly one cycle: the cycle after the clk edge that samples its cause.
- Long-press latency: the `btn_level` rise is sampled at edge E; `long_press` is high in cycle E + 1 + `LONG_MS`·`TICK_CYC`.
- Repeat pulses are spaced exactly `REPEAT_MS`·`TICK_CYC` cycles apart. The first repeat pulse comes that same spacing after `long_press`.
- Short press with the feature enabled: `short_press` is high `DOUBLE_MS`·`TICK_CYC` + 1 cycles after the release edge.
- Short press without the feature: `short_press` is high 1 cycle after the release edge.
- Reset, including mid-operation: all outputs go to 0 immediately (asynchronous), the FSM goes to WAIT_RELEASE, and the counters clear. No pulse is emitted because of reset.

## Configuration
- Macro `BUTTON_DOUBLE_PRESS_EN`.
- Defined: WAIT_SECOND and SECOND_PRESSED exist, and short-press latency includes the `DOUBLE_MS` window.
- Undefined:
  - Both states are removed.
  - PRESSED release goes directly to `short_press`.
  - `double_press` is tied to 0.
  - `DOUBLE_MS` is unused.

## Structure
- Package `button_pkg`:
  - FSM state enum `btn_state_t`.
  - Function `ms_to_ticks(CLK_PER)`.
  - Pulse-type localparams.
- Sub-module `ms_tick_gen`: prescaler with a synchronous `clear` input and a one-cycle `tick` output.
- The FSM and the ms counter live in `button_press_classifier`.

## Test plan
Sim parameters are `CLK_PER`=100000 (`TICK_CYC`=10), `LONG_MS`=5, `REPEAT_MS`=3, `DOUBLE_MS`=4.
- Hold for 20 cycles, then release, with the feature off -> one `short_press`, 1 cycle after the release edge; no other pulses.
- Hold for 120 cycles -> `long_press` at cycle 51 after the rise, then `repeat_press` at +30 and +60; `held` is high from the `long_press` cycle until the release edge.
- With the feature on: press 20, release 20, press 20, release -> one `double_press` 1 cycle after the second release; no `short_press`.
- With the feature on: press 20, release, idle 60 -> `short_press` exactly 41 cycles after the release edge.
- `btn_level` high when `CPU_RESETN` deasserts and held for 100 cycles -> no pulses. After a release and a 20-cycle press -> `short_press`.
- Assert `CPU_RESETN` low at cycle 30 of a hold -> all outputs are 0 at once and no `long_press` ever follows. Release the button, then press for 20 cycles -> `short_press`.
